// File: rtl/matmul_feeder.sv
// Operand sequencer for the MAX_DIM x MAX_DIM systolic array: reads A columns / B rows, skews, zero-pads.
// Optional stall input enabled by defining MATMUL_FEEDER_STALL_EN.

module matmul_feeder_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  adv_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] a_q, b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= '0;
            b_q <= '0;
        end else if (adv_i) begin
            a_q[0] <= a_i;
            b_q[0] <= b_i;
            for (int s = 1; s < DEPTH; s++) begin
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
            end
        end
    end

    assign a_o = a_q[DEPTH-1];
    assign b_o = b_q[DEPTH-1];
endmodule

module matmul_feeder #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  MAX_DIM      = 4,
    parameter int  FLUSH_CYCLES = 2*MAX_DIM-1,
    localparam int AW           = $clog2(MAX_DIM),
    localparam int DW           = $clog2(MAX_DIM)+1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
`ifdef MATMUL_FEEDER_STALL_EN
    input  logic                          stall_i,
`endif
    input  logic [DW-1:0]                 dim_m_i,
    input  logic [DW-1:0]                 dim_k_i,
    input  logic [DW-1:0]                 dim_n_i,
    output logic                          rd_en_o,
    output logic [AW-1:0]                 rd_addr_o,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_data_a_i,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_data_b_i,
    output logic [MAX_DIM*DATA_WIDTH-1:0] left_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0] up_o,
    output logic                          clr_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);
    localparam int CW = $clog2(MAX_DIM+FLUSH_CYCLES+1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e              state_q;
    logic [DW-1:0]       m_q, k_q, n_q;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       rd_addr_q;
    logic                rd_en_q, clr_q, done_q, err_q, busy_q, vld_q;
    logic                stall, dims_ok, last_rd;
    logic                src_vld;
    logic [MAX_DIM*DATA_WIDTH-1:0] src_a, src_b, left_raw, up_raw;

`ifdef MATMUL_FEEDER_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign dims_ok = (dim_m_i != '0) && (dim_m_i <= DW'(MAX_DIM)) &&
                     (dim_k_i != '0) && (dim_k_i <= DW'(MAX_DIM)) &&
                     (dim_n_i != '0) && (dim_n_i <= DW'(MAX_DIM));
    assign last_rd = ({1'b0, rd_addr_q} == (k_q - DW'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            // Read data lands one cycle after the (possibly stall-gated) enable.
            vld_q <= rd_en_o;
            if (!stall) begin
                clr_q  <= 1'b0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
                unique case (state_q)
                    IDLE: if (start_i) begin
                        m_q    <= dim_m_i;
                        k_q    <= dim_k_i;
                        n_q    <= dim_n_i;
                        busy_q <= 1'b1;
                        if (dims_ok) begin
                            state_q   <= READ;
                            clr_q     <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                    READ: if (last_rd) begin
                        state_q   <= DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        cnt_q     <= CW'(MAX_DIM+FLUSH_CYCLES);
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                    DRAIN: if (cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef MATMUL_FEEDER_STALL_EN
    // Data returning during a stall is parked here; at most one read is ever outstanding.
    logic                          hold_vld_q;
    logic [MAX_DIM*DATA_WIDTH-1:0] hold_a_q, hold_b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld_q <= 1'b0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else if (stall && vld_q) begin
            hold_vld_q <= 1'b1;
            hold_a_q   <= rd_data_a_i;
            hold_b_q   <= rd_data_b_i;
        end else if (!stall) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign src_vld = vld_q | hold_vld_q;
    assign src_a   = hold_vld_q ? hold_a_q : rd_data_a_i;
    assign src_b   = hold_vld_q ? hold_b_q : rd_data_b_i;
`else
    assign src_vld = vld_q;
    assign src_a   = rd_data_a_i;
    assign src_b   = rd_data_b_i;
`endif

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_in, b_in;
        assign a_in = (src_vld && (DW'(i) < m_q)) ? src_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_in = (src_vld && (DW'(i) < n_q)) ? src_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        matmul_feeder_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i+1)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .adv_i  (!stall),
            .a_i    (a_in),
            .b_i    (b_in),
            .a_o    (left_raw[i*DATA_WIDTH +: DATA_WIDTH]),
            .b_o    (up_raw[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign rd_en_o   = rd_en_q & ~stall;
    assign rd_addr_o = rd_addr_q;
    assign left_o    = stall ? '0 : left_raw;
    assign up_o      = stall ? '0 : up_raw;
    assign clr_o     = clr_q & ~stall;
    assign busy_o    = busy_q;
    assign done_o    = done_q & ~stall;
    assign err_o     = err_q & ~stall;
endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: per-cycle expectations derived from the documented timing.
module tb_matmul_feeder;
    localparam int DWD = 32;
    localparam int MD  = 4;
    localparam int FL  = 2*MD-1;
    localparam int AW  = $clog2(MD);
    localparam int DW  = $clog2(MD)+1;

    typedef struct packed {
        logic [MD*DWD-1:0] left;
        logic [MD*DWD-1:0] up;
        logic              clr;
        logic              busy;
        logic              done;
        logic              err;
        logic              rd_en;
        logic [AW-1:0]     addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [DW-1:0] dm = '0, dk = '0, dn = '0;
    logic rd_en;
    logic [AW-1:0] rd_addr;
    logic [MD*DWD-1:0] rda = '0, rdb = '0, left, up;
    logic clr, busy, done, err;
`ifdef MATMUL_FEEDER_STALL_EN
    logic stall = 1'b0;
`endif

    int abase = 0, bbase = 100;
    int vectors = 0, errors = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    matmul_feeder #(.DATA_WIDTH(DWD), .MAX_DIM(MD), .FLUSH_CYCLES(FL)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
`ifdef MATMUL_FEEDER_STALL_EN
        .stall_i     (stall),
`endif
        .dim_m_i     (dm),
        .dim_k_i     (dk),
        .dim_n_i     (dn),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .rd_data_a_i (rda),
        .rd_data_b_i (rdb),
        .left_o      (left),
        .up_o        (up),
        .clr_o       (clr),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    // Operand memories: 1-cycle synchronous read of a whole A column / B row.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < MD; i++) begin
                rda[i*DWD +: DWD] <= DWD'(abase + 16*int'(rd_addr) + i);
                rdb[i*DWD +: DWD] <= DWD'(bbase + 16*int'(rd_addr) + i);
            end
        end
    end

    function automatic bit legal(int m, int k, int n);
        return m >= 1 && m <= MD && k >= 1 && k <= MD && n >= 1 && n <= MD;
    endfunction

    // Expected outputs in cycle t0+n of an unstalled run.
    function automatic obs_t base_model(int n, int m, int k, int nn);
        obs_t o;
        int dn_cyc, kk;
        o = '0;
        if (!legal(m, k, nn)) begin
            if (n == 1) begin o.busy = 1'b1; o.done = 1'b1; o.err = 1'b1; end
            return o;
        end
        dn_cyc  = k + MD + 2 + FL;
        o.clr   = (n == 1);
        o.rd_en = (n >= 1 && n <= k);
        o.addr  = o.rd_en ? AW'(n-1) : '0;
        o.busy  = (n >= 1 && n <= dn_cyc);
        o.done  = (n == dn_cyc);
        for (int i = 0; i < MD; i++) begin
            kk = n - 3 - i;
            if (kk >= 0 && kk < k) begin
                if (i < m)  o.left[i*DWD +: DWD] = DWD'(abase + 16*kk + i);
                if (i < nn) o.up[i*DWD +: DWD]   = DWD'(bbase + 16*kk + i);
            end
        end
        return o;
    endfunction

    // A stall of sl cycles starting in cycle s0 freezes everything and blanks the array-facing outputs.
    function automatic obs_t model(int n, int m, int k, int nn, int s0, int sl);
        obs_t o;
        if (sl > 0 && n >= s0 && n < s0 + sl) begin
            o = base_model(s0, m, k, nn);
            o.left = '0; o.up = '0; o.rd_en = 1'b0; o.clr = 1'b0; o.done = 1'b0; o.err = 1'b0;
            o.addr = base_model(s0, m, k, nn).addr;
        end else if (sl > 0 && n >= s0 + sl) begin
            o = base_model(n - sl, m, k, nn);
        end else begin
            o = base_model(n, m, k, nn);
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.left = left; o.up = up; o.clr = clr; o.busy = busy;
        o.done = done; o.err = err; o.rd_en = rd_en; o.addr = rd_addr;
        return o;
    endfunction

    task automatic launch(input int m, input int k, input int n);
        @(negedge clk);
        dm = DW'(m); dk = DW'(k); dn = DW'(n);
        start = 1'b1;
    endtask

    // Follows the run from t0+1; the caller has already raised start for edge t0.
    task automatic check_run(input string name, input int m, input int k, input int nn, input bit keep,
                             input int nm, input int nk, input int nnn, input int s0, input int sl);
        int L;
        obs_t e, a;
        L = legal(m, k, nn) ? (k + MD + 2 + FL + 1 + sl) : 2;
        for (int n = 1; n <= L; n++) exp_q.push_back(model(n, m, k, nn, s0, sl));
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        for (int n = 1; n <= L; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
`ifdef MATMUL_FEEDER_STALL_EN
            stall = (sl > 0 && n >= s0 && n < s0 + sl);
`endif
            if (n == 2) begin dm = DW'(nm); dk = DW'(nk); dn = DW'(nnn); end
            #1;
            e = exp_q.pop_front();
            a = sample();
            if (!e.rd_en) a.addr = '0;
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s t0+%0d got left=%h up=%h clr/busy/done/err/rd_en=%b%b%b%b%b addr=%0d exp left=%h up=%h clr/busy/done/err/rd_en=%b%b%b%b%b addr=%0d",
                         name, n, a.left, a.up, a.clr, a.busy, a.done, a.err, a.rd_en, a.addr,
                         e.left, e.up, e.clr, e.busy, e.done, e.err, e.rd_en, e.addr);
            end
        end
    endtask

    task automatic test_reset();
        obs_t a;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        a = sample();
        vectors++;
        if (a !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", a);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full();
        abase = 0; bbase = 100;
        launch(4, 4, 4);
        check_run("full_4x4x4", 4, 4, 4, 1'b0, 4, 4, 4, 0, 0);
    endtask

    task automatic test_small();
        abase = 5; bbase = 60;
        launch(2, 2, 3);
        check_run("small_2x2x3", 2, 2, 3, 1'b0, 2, 2, 3, 0, 0);
    endtask

    task automatic test_illegal();
        launch(4, 0, 4);
        check_run("illegal_k0", 4, 0, 4, 1'b0, 4, 0, 4, 0, 0);
        launch(4, 4, 5);
        check_run("illegal_n5", 4, 4, 5, 1'b0, 4, 4, 5, 0, 0);
    endtask

    // Start held through a run with dims changing mid-run: one run, then a second one in the cycle after done.
    task automatic test_start_held();
        abase = 32; bbase = 200;
        launch(4, 4, 4);
        check_run("held_first", 4, 4, 4, 1'b1, 2, 3, 4, 0, 0);
        check_run("held_second", 2, 3, 4, 1'b0, 2, 3, 4, 0, 0);
    endtask

    task automatic test_back_to_back();
        abase = 9; bbase = 140;
        launch(3, 1, 2);
        check_run("b2b_first", 3, 1, 2, 1'b0, 3, 1, 2, 0, 0);
        launch(1, 4, 1);
        check_run("b2b_second", 1, 4, 1, 1'b0, 1, 4, 1, 0, 0);
    endtask

    task automatic test_mid_reset();
        obs_t e, a;
        abase = 0; bbase = 100;
        launch(4, 4, 4);
        for (int n = 1; n <= 4; n++) exp_q.push_back(model(n, 4, 4, 4, 0, 0));
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            #1;
            e = exp_q.pop_front();
            a = sample();
            if (!e.rd_en) a.addr = '0;
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL mid_reset_pre t0+%0d got %h exp %h", n, a, e);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        a = sample();
        vectors++;
        if (a !== obs_t'('0)) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #2;
            a = sample();
            vectors++;
            if (a !== obs_t'('0)) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d got %h exp 0", n, a);
            end
        end
    endtask

`ifdef MATMUL_FEEDER_STALL_EN
    task automatic test_stall();
        abase = 0; bbase = 100;
        launch(4, 4, 4);
        check_run("stall_4x4x4", 4, 4, 4, 1'b0, 4, 4, 4, 3, 3);
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_small();
        test_illegal();
        test_start_held();
        test_back_to_back();
        test_mid_reset();
        test_small();
`ifdef MATMUL_FEEDER_STALL_EN
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/matmul_feeder.md
# matmul_feeder

Parametrised operand sequencer for the MAX_DIM×MAX_DIM systolic multiplier. On a start pulse it streams column k of A and row k of B from the row-wide operand memories, applies the diagonal skew the array needs, and zero-pads unused lanes for runtime dimensions M×K·K×N ≤ MAX_DIM. It also clears the array accumulators, tracks drain latency, and reports busy/done to the APB control register file.

## Interface
- DATA_WIDTH, 32, element width (8/16/32)
- MAX_DIM, 4, array side; ≥2
- FLUSH_CYCLES, 2*MAX_DIM-1, array drain cycles after last skewed operand
- AW = $clog2(MAX_DIM) (derived), DW = $clog2(MAX_DIM)+1 (derived)
- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  start request, sampled in IDLE only
- dim_m_i, dim_k_i, dim_n_i  in  DW each  dimensions, legal 1..MAX_DIM, latched at start
- rd_en_o  out  1  operand memory read enable (A and B shared)
- rd_addr_o  out  AW  k index: A column k, B row k
- rd_data_a_i  in  MAX_DIM*DATA_WIDTH  A column, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]; 1-cycle sync read
- rd_data_b_i  in  MAX_DIM*DATA_WIDTH  B row, lane j likewise
- left_o  out  MAX_DIM*DATA_WIDTH  skewed A lanes to array rows
- up_o  out  MAX_DIM*DATA_WIDTH  skewed B lanes to array columns
- clr_o  out  1  one-cycle accumulator clear to array
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with done_o on illegal dimensions

## Operation
- FSM: IDLE → READ → DRAIN → DONE → IDLE.
- IDLE: start_i=1 latches dims. Legal dims → READ, clr_o=1 next cycle. Any dim 0 or >MAX_DIM → DONE directly with err_o; no reads issued.
- READ: K cycles, rd_en_o=1, rd_addr_o=0..K-1, then DRAIN.
- Skew: lane i delayed i extra cycles via shift chain depth i. Lane i of left_o is zero unless carrying valid A data with i<M; lane j of up_o is zero unless carrying valid B data with j<N. Bubble cycles inject zeros.
- DRAIN: down-counter loaded with MAX_DIM+FLUSH_CYCLES; when it reaches 0 → DONE.
- DONE: done_o=1 (err_o if illegal) for one cycle → IDLE.
- busy_o=1 in READ, DRAIN, DONE.
- start_i outside IDLE is ignored; dims not re-latched.
- Reset (any time, including mid-operation) clears state, counters and skew registers. Reset values: all outputs 0; FSM IDLE.

## Timing
- start sampled at edge t0. clr_o high in cycle t0+1.
- rd_addr_o=k during cycle t0+1+k. Data on rd_data_*_i during t0+2+k.
- Lane i output visible in cycle t0+3+k+i (registered).
- Last operand: t0+K+MAX_DIM+1. done_o in cycle t0+K+MAX_DIM+2+FLUSH_CYCLES.
- Illegal dims: done_o and err_o in cycle t0+1; busy_o high in that cycle only.
- Back-to-back: start_i may be high in the cycle after done_o and is accepted.

## Configuration
- MATMUL_FEEDER_STALL_EN defined: adds input stall_i (1 bit). While stall_i=1, FSM, counters, rd_addr_o and skew chains hold; rd_en_o=0; left_o/up_o drive zero. done_o cannot assert during stall. The run then completes that many cycles later.
- Undefined: no stall_i port; timing exactly as above.

## Test plan
- MAX_DIM=4, M=K=N=4; A column k lane i = 16k+i; B row k lane j = 100+16k+j; start at t0 → left_o lane 2 = 34 (k=2) in t0+7; up_o lane 3 = 119 (k=1) in t0+7; done_o in t0+17.
- M=2, K=2, N=3 → rd_addr_o 0,1 in t0+1..t0+2; left_o lanes 2,3 and up_o lane 3 always 0; done_o in t0+15.
- start_i held high throughout run → single run; second start accepted only in the cycle after done_o.
- dim_k_i=0 or dim_n_i=5 → err_o=done_o=1 in t0+1; rd_en_o never asserted.
- rst_ni low at t0+4 of a 4×4 run → all outputs 0 immediately (asynchronous); after release, IDLE and new start accepted.
- With MATMUL_FEEDER_STALL_EN: 3-cycle stall at t0+3, 4×4 run → left_o sequence shifted by 3 cycles; done_o in t0+20.
